// File: rtl/interp_lut_fetcher_pkg.sv
// interp_lut_fetcher_pkg: shared LUT-activation parameters, fetch states and x-to-index mapping
package interp_lut_fetcher_pkg;
    localparam int WIDTH = 8;
    localparam int FRAC  = 4;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_BASE, RD_NEXT, OUT} fetch_state_t;

    // Offset-binary index: the signed integer part of x shifted up by DEPTH/2
    function automatic logic [AW-1:0] lut_idx(input logic [WIDTH-1:0] x);
        return AW'((x >> FRAC) + WIDTH'(DEPTH / 2));
    endfunction
endpackage

// File: rtl/lut_spram.sv
// lut_spram: single-port synchronous-read RAM, one address shared by write and read
module lut_spram
    import interp_lut_fetcher_pkg::*;
(
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/interp_lut_fetcher.sv
// interp_lut_fetcher: splits x into index/fraction and fetches two adjacent LUT entries
module interp_lut_fetcher
    import interp_lut_fetcher_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             tbl_we,
    input  logic [AW-1:0]    tbl_addr,
    input  logic [WIDTH-1:0] tbl_wdata,
    output logic             tbl_ack,
    output logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] next_data,
    output logic [WIDTH-1:0] change,
    output logic [WIDTH-1:0] remaining,
    output logic             out_valid,
    input  logic             out_ready
);
    fetch_state_t     r_state, w_next;
    logic [WIDTH-1:0] r_x, r_base, r_next, r_change, r_rem, w_rdata;
    logic [AW-1:0]    w_idx, w_addr;

    assign w_idx = lut_idx(r_x);

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        tbl_ack  = 1'b0;
        w_addr   = w_idx;
        case (r_state)
            IDLE: begin
                in_ready = !tbl_we && !rst;
                tbl_ack  = tbl_we && !rst;
                w_addr   = tbl_we ? tbl_addr : lut_idx(in_x);
                w_next   = (in_valid && in_ready) ? RD_BASE : IDLE;
            end
            RD_BASE: begin
                // The last entry has no successor, so it is its own neighbour
                w_addr = (w_idx == AW'(DEPTH - 1)) ? w_idx : w_idx + AW'(1);
                w_next = RD_NEXT;
            end
            RD_NEXT: w_next = OUT;
            OUT:     w_next = out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base   <= '0;
            r_next   <= '0;
            r_change <= '0;
            r_rem    <= '0;
        end else begin
            if (r_state == IDLE && in_valid && in_ready) r_x <= in_x;
            if (r_state == RD_BASE) r_base <= w_rdata;
            if (r_state == RD_NEXT) begin
                r_next   <= w_rdata;
                r_change <= w_rdata - r_base;
                r_rem    <= {{(WIDTH - FRAC){1'b0}}, r_x[FRAC-1:0]};
            end
        end
    end

    lut_spram u_ram (
        .clk     (clk),
        .i_we    (tbl_ack),
        .i_addr  (w_addr),
        .i_wdata (tbl_wdata),
        .o_rdata (w_rdata)
    );

    assign base      = r_base;
    assign next_data = r_next;
    assign change    = r_change;
    assign remaining = r_rem;
    assign out_valid = r_state == OUT;
endmodule
